// File: rtl/priority_encoder83.sv
// Sequential 8-to-3 priority encoder: collects request pulses into a pending set and
// presents their indices, highest first, over a valid/ready handshake.
module priority_encoder83 #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  req,
    input  logic              ready,
    output logic              valid,
    output logic [CODE_W-1:0] code,
    output logic [WIDTH-1:0]  pending,
    output logic              coalesce
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state, state_next;
    logic               fire;
    logic [WIDTH-1:0]   served;
    logic [WIDTH-1:0]   pending_next;
    logic [CODE_W-1:0]  sel;
    logic               load_code;

    assign fire         = (state == HOLD) && ready;
    assign served       = fire ? (WIDTH'(1) << code) : '0;
    assign pending_next = (pending & ~served) | req;

    // Ascending scan so the highest set index is the last one written.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (pending_next[i]) begin
                sel = CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_code  = 1'b0;
        case (state)
            IDLE: begin
                if (pending_next != '0) begin
                    state_next = HOLD;
                    load_code  = 1'b1;
                end
            end
            HOLD: begin
                if (fire) begin
                    if (pending_next != '0) begin
                        load_code = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        valid = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code     <= '0;
            pending  <= '0;
            coalesce <= 1'b0;
        end else begin
            if (load_code) begin
                code <= sel;
            end
            pending  <= pending_next;
            coalesce <= |(req & pending & ~served);
        end
    end

endmodule

// File: tb/tb_priority_encoder83.sv
// Bench for priority_encoder83: directed scenarios plus random traffic, all checked
// cycle by cycle against a set-based reference model.
module tb_priority_encoder83;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       ready;
    logic       valid;
    logic [2:0] code;
    logic [7:0] pending;
    logic       coalesce;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    bit m_set[8];
    bit m_valid;
    int m_code;
    bit m_coal;

    priority_encoder83 #(.WIDTH(8), .CODE_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ready    (ready),
        .valid    (valid),
        .code     (code),
        .pending  (pending),
        .coalesce (coalesce)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_pending();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[i] = m_set[i];
        return v;
    endfunction

    function automatic int highest_in(input bit s[8]);
        for (int i = 7; i >= 0; i--) if (s[i]) return i;
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit nxt[8];
        bit take;
        int h;
        take = m_valid && ready;
        if (rst) begin
            foreach (m_set[i]) m_set[i] = 0;
            m_valid = 0;
            m_code  = 0;
            m_coal  = 0;
            return;
        end
        m_coal = 0;
        foreach (nxt[i]) begin
            bit is_served;
            is_served = take && (i == m_code);
            if (req[i] && m_set[i] && !is_served) m_coal = 1;
            nxt[i] = (m_set[i] && !is_served) || req[i];
        end
        if (!m_valid || take) begin
            h = highest_in(nxt);
            if (h >= 0) begin
                m_valid = 1;
                m_code  = h;
            end else begin
                m_valid = 0;
            end
        end
        m_set = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("valid", 32'(valid), 32'(m_valid));
        check("code", 32'(code), 32'(m_code));
        check("pending", 32'(pending), 32'(model_pending()));
        check("coalesce", 32'(coalesce), 32'(m_coal));
    endtask

    initial begin
        foreach (m_set[i]) m_set[i] = 0;
        m_valid = 0;
        m_code  = 0;
        m_coal  = 0;
        rst = 1'b1; req = '0; ready = 1'b0;

        tick(); tick();
        check("rst_valid", 32'(valid), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_code", 32'(code), 0);

        // T1
        rst = 1'b0; req = 8'h04; ready = 1'b1;
        tick();
        check("t1_valid", 32'(valid), 1);
        check("t1_code", 32'(code), 2);
        check("t1_pending", 32'(pending), 32'h04);
        req = '0;
        tick();
        check("t1_idle", 32'(valid), 0);

        // T2
        req = 8'hA1; tick(); check("t2_c7", 32'(code), 7);
        req = '0;    tick(); check("t2_c5", 32'(code), 5); check("t2_p21", 32'(pending), 32'h21);
        tick();      check("t2_c0", 32'(code), 0); check("t2_p01", 32'(pending), 32'h01);
        tick();      check("t2_idle", 32'(valid), 0);

        // T3
        ready = 1'b0; req = 8'h80; tick();
        req = 8'h08; tick();
        check("t3_hold_code", 32'(code), 7);
        check("t3_pend", 32'(pending), 32'h88);
        req = '0; ready = 1'b1; tick();
        check("t3_c3", 32'(code), 3);
        tick();
        check("t3_idle", 32'(valid), 0);

        // T4
        ready = 1'b0; req = 8'h20; tick();
        ready = 1'b1; req = 8'h20; tick();
        check("t4_code", 32'(code), 5);
        check("t4_valid", 32'(valid), 1);
        check("t4_coal", 32'(coalesce), 0);
        req = '0; tick();

        // T5
        ready = 1'b0; req = 8'h20; tick();
        req = 8'h20; tick();
        check("t5_coal", 32'(coalesce), 1);
        check("t5_pend", 32'(pending), 32'h20);
        req = '0; tick();
        check("t5_coal_end", 32'(coalesce), 0);
        ready = 1'b1; tick();

        // T6
        ready = 1'b0; req = 8'hFF; tick();
        rst = 1'b1; req = 8'h01; tick();
        check("t6_valid", 32'(valid), 0);
        check("t6_pend", 32'(pending), 0);
        check("t6_code", 32'(code), 0);
        rst = 1'b0; req = '0; tick();
        check("t6_quiet", 32'(valid), 0);

        // Random traffic: sparse requests, random backpressure, occasional reset
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom) & 8'($urandom);
            req   = ($urandom_range(0, 3) == 0) ? r : '0;
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
